// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that sequences held commands onto a
// single-port memory, one access in flight, and routes read data back.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  r0_req,
    input  logic                  r0_wr,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ack,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_rvalid,
    input  logic                  r1_req,
    input  logic                  r1_wr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ack,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wr_en,
    output logic                  mem_op_en,
    output logic                  mem_cs,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY);

    state_t                state, next_state;
    logic [2:0]            cnt;
    logic                  lat_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_id;
    logic                  last_id;
    logic                  any_req;
    logic                  win_id;

    // On contention the requester not granted last wins; a lone requester always wins.
    assign any_req = r0_req | r1_req;
    assign win_id  = (r0_req && r1_req) ? ~last_id : r1_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = lat_wr ? IDLE : WAIT;
            WAIT:    if (cnt <= 3'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_cs      = 1'b0;
        mem_op_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        r0_ack      = 1'b0;
        r1_ack      = 1'b0;
        r0_rvalid   = 1'b0;
        r1_rvalid   = 1'b0;
        if (state == ISSUE) begin
            mem_cs      = 1'b1;
            mem_op_en   = 1'b1;
            mem_wr_en   = lat_wr;
            mem_addr    = lat_addr;
            mem_data_in = lat_wr ? lat_wdata : '0;
            r0_ack      = ~lat_id;
            r1_ack      = lat_id;
        end else if (state == RESP) begin
            r0_rvalid = ~lat_id;
            r1_rvalid = lat_id;
        end
    end

    // Command capture, latency counter and per-requester read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_id    <= 1'b0;
            last_id   <= 1'b1;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            unique case (state)
                IDLE: if (any_req) begin
                    lat_id    <= win_id;
                    last_id   <= win_id;
                    lat_wr    <= win_id ? r1_wr    : r0_wr;
                    lat_addr  <= win_id ? r1_addr  : r0_addr;
                    lat_wdata <= win_id ? r1_wdata : r0_wdata;
                end
                ISSUE: if (!lat_wr) cnt <= LAT_LOAD;
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        if (lat_id) r1_rdata <= mem_data_out;
                        else        r0_rdata <= mem_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 built with RD_LATENCY=1,
// instance 1 with RD_LATENCY=3, each with its own behavioural memory.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       r0_req[2], r0_wr[2], r0_ack[2], r0_rvalid[2];
    logic       r1_req[2], r1_wr[2], r1_ack[2], r1_rvalid[2];
    logic [3:0] r0_addr[2], r1_addr[2], mem_addr[2];
    logic [7:0] r0_wdata[2], r1_wdata[2], r0_rdata[2], r1_rdata[2];
    logic [7:0] mem_data_in[2], mem_data_out[2];
    logic       mem_wr_en[2], mem_op_en[2], mem_cs[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .reset_n(reset_n),
            .r0_req(r0_req[g]), .r0_wr(r0_wr[g]), .r0_addr(r0_addr[g]), .r0_wdata(r0_wdata[g]),
            .r0_ack(r0_ack[g]), .r0_rdata(r0_rdata[g]), .r0_rvalid(r0_rvalid[g]),
            .r1_req(r1_req[g]), .r1_wr(r1_wr[g]), .r1_addr(r1_addr[g]), .r1_wdata(r1_wdata[g]),
            .r1_ack(r1_ack[g]), .r1_rdata(r1_rdata[g]), .r1_rvalid(r1_rvalid[g]),
            .mem_addr(mem_addr[g]), .mem_data_in(mem_data_in[g]), .mem_wr_en(mem_wr_en[g]),
            .mem_op_en(mem_op_en[g]), .mem_cs(mem_cs[g]), .mem_data_out(mem_data_out[g])
        );
    end

    // Memory models: read data appears RD_LATENCY cycles after the sampling edge, else 0.
    logic [7:0] mem_a[16], mem_b[16];
    logic [7:0] pa, pb0, pb1, pb2;

    always @(posedge clk) begin
        if (mem_cs[0] && mem_op_en[0] && mem_wr_en[0]) mem_a[mem_addr[0]] <= mem_data_in[0];
        pa <= (mem_cs[0] && mem_op_en[0] && !mem_wr_en[0]) ? mem_a[mem_addr[0]] : 8'h00;
    end
    assign mem_data_out[0] = pa;

    always @(posedge clk) begin
        if (mem_cs[1] && mem_op_en[1] && mem_wr_en[1]) mem_b[mem_addr[1]] <= mem_data_in[1];
        pb0 <= (mem_cs[1] && mem_op_en[1] && !mem_wr_en[1]) ? mem_b[mem_addr[1]] : 8'h00;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign mem_data_out[1] = pb2;

    function automatic logic [34:0] outs(int k);
        return {r0_ack[k], r0_rdata[k], r0_rvalid[k], r1_ack[k], r1_rdata[k], r1_rvalid[k],
                mem_addr[k], mem_data_in[k], mem_wr_en[k], mem_op_en[k], mem_cs[k]};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs(int k);
        r0_req[k] = 1'b0; r0_wr[k] = 1'b0; r0_addr[k] = '0; r0_wdata[k] = '0;
        r1_req[k] = 1'b0; r1_wr[k] = 1'b0; r1_addr[k] = '0; r1_wdata[k] = '0;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) clear_inputs(k);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 2; k++) begin
                r0_req[k] = 1'($urandom); r0_wr[k] = 1'($urandom);
                r0_addr[k] = 4'($urandom); r0_wdata[k] = 8'($urandom);
                r1_req[k] = 1'($urandom); r1_wr[k] = 1'($urandom);
                r1_addr[k] = 4'($urandom); r1_wdata[k] = 8'($urandom);
            end
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (outs(k) !== 35'h0) begin
                errors++;
                $display("FAIL reset_async_outs inst%0d got %h exp 0", k, outs(k));
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) clear_inputs(k);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (mem_cs[0] !== 1'b0 || mem_cs[1] !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_cs cycle %0d got %b%b exp 00", c, mem_cs[1], mem_cs[0]);
            end
        end
    endtask

    task automatic test_write;
        r0_req[0] = 1'b1; r0_wr[0] = 1'b1; r0_addr[0] = 4'h3; r0_wdata[0] = 8'hA5;
        tick();
        checks++;
        if ({mem_cs[0], mem_op_en[0], mem_wr_en[0], mem_addr[0], mem_data_in[0], r0_ack[0], r1_ack[0]}
            !== {1'b1, 1'b1, 1'b1, 4'h3, 8'hA5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL write_issue got cs%b op%b we%b a%h d%h ack%b%b exp 111 3 a5 ack01",
                     mem_cs[0], mem_op_en[0], mem_wr_en[0], mem_addr[0], mem_data_in[0], r1_ack[0], r0_ack[0]);
        end
        r0_req[0] = 1'b0;
        tick();
        checks++;
        if ({mem_cs[0], r0_ack[0], r0_rvalid[0], r1_rvalid[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL write_idle got cs%b ack%b rv%b%b exp all 0",
                     mem_cs[0], r0_ack[0], r0_rvalid[0], r1_rvalid[0]);
        end
    endtask

    task automatic test_read_lat1;
        r1_req[0] = 1'b1; r1_wr[0] = 1'b0; r1_addr[0] = 4'h3;
        tick();
        checks++;
        if ({mem_cs[0], mem_wr_en[0], mem_addr[0], mem_data_in[0], r1_ack[0], r0_ack[0]}
            !== {1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read_issue got cs%b we%b a%h d%h ack1=%b ack0=%b exp cs1 we0 a3 d00 ack1=1",
                     mem_cs[0], mem_wr_en[0], mem_addr[0], mem_data_in[0], r1_ack[0], r0_ack[0]);
        end
        r1_req[0] = 1'b0;
        tick();
        checks++;
        if ({mem_cs[0], r1_rvalid[0]} !== 2'b00) begin
            errors++;
            $display("FAIL read_wait got cs%b rv%b exp 00", mem_cs[0], r1_rvalid[0]);
        end
        tick();
        checks++;
        if ({r1_rvalid[0], r1_rdata[0], r0_rvalid[0], r0_rdata[0]} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL read_resp got rv1=%b d1=%h rv0=%b d0=%h exp 1 a5 0 00",
                     r1_rvalid[0], r1_rdata[0], r0_rvalid[0], r0_rdata[0]);
        end
        tick();
        checks++;
        if ({r1_rvalid[0], r1_rdata[0]} !== {1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL read_hold got rv%b d%h exp 0 a5", r1_rvalid[0], r1_rdata[0]);
        end
    endtask

    task automatic test_back_to_back;
        logic       exp_cs, exp_a0, exp_a1;
        logic [3:0] exp_addr;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        r0_req[0] = 1'b1; r0_wr[0] = 1'b1; r0_addr[0] = 4'h1; r0_wdata[0] = 8'h11;
        r1_req[0] = 1'b1; r1_wr[0] = 1'b1; r1_addr[0] = 4'h2; r1_wdata[0] = 8'h22;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_cs   = (i % 2 == 0);
            exp_a0   = (i % 4 == 0);
            exp_a1   = (i % 4 == 2);
            exp_addr = exp_a0 ? 4'h1 : (exp_a1 ? 4'h2 : 4'h0);
            checks++;
            if ({mem_cs[0], r0_ack[0], r1_ack[0], mem_addr[0]} !== {exp_cs, exp_a0, exp_a1, exp_addr}) begin
                errors++;
                $display("FAIL rr_order cycle %0d got cs%b ack0=%b ack1=%b a%h exp cs%b ack0=%b ack1=%b a%h",
                         i, mem_cs[0], r0_ack[0], r1_ack[0], mem_addr[0], exp_cs, exp_a0, exp_a1, exp_addr);
            end
        end
        clear_inputs(0);
        tick();
    endtask

    task automatic test_read_lat3;
        r0_req[1] = 1'b1; r0_wr[1] = 1'b1; r0_addr[1] = 4'h7; r0_wdata[1] = 8'h5C;
        tick();
        r0_req[1] = 1'b0;
        tick();
        r0_req[1] = 1'b1; r0_wr[1] = 1'b0; r0_addr[1] = 4'h7;
        tick();
        checks++;
        if ({r0_ack[1], mem_cs[1], mem_wr_en[1]} !== 3'b110) begin
            errors++;
            $display("FAIL lat3_issue got ack%b cs%b we%b exp 110", r0_ack[1], mem_cs[1], mem_wr_en[1]);
        end
        r0_req[1] = 1'b0;
        tick();
        r1_req[1] = 1'b1; r1_wr[1] = 1'b1; r1_addr[1] = 4'h9; r1_wdata[1] = 8'h33;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            checks++;
            if ({r0_rvalid[1], r1_ack[1], mem_cs[1]} !== 3'b000) begin
                errors++;
                $display("FAIL lat3_wait T+%0d got rv%b ack1=%b cs%b exp 000", c, r0_rvalid[1], r1_ack[1], mem_cs[1]);
            end
        end
        tick();
        checks++;
        if ({r0_rvalid[1], r0_rdata[1], r1_ack[1]} !== {1'b1, 8'h5C, 1'b0}) begin
            errors++;
            $display("FAIL lat3_resp got rv%b d%h ack1=%b exp 1 5c 0", r0_rvalid[1], r0_rdata[1], r1_ack[1]);
        end
        tick();
        checks++;
        if ({r0_rvalid[1], r1_ack[1], mem_cs[1]} !== 3'b000) begin
            errors++;
            $display("FAIL lat3_idle got rv%b ack1=%b cs%b exp 000", r0_rvalid[1], r1_ack[1], mem_cs[1]);
        end
        tick();
        checks++;
        if ({r1_ack[1], mem_cs[1], mem_addr[1], mem_data_in[1]} !== {1'b1, 1'b1, 4'h9, 8'h33}) begin
            errors++;
            $display("FAIL lat3_r1_issue got ack1=%b cs%b a%h d%h exp 1 1 9 33",
                     r1_ack[1], mem_cs[1], mem_addr[1], mem_data_in[1]);
        end
        r1_req[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read;
        r0_req[1] = 1'b1; r0_wr[1] = 1'b0; r0_addr[1] = 4'h7;
        tick();
        r0_req[1] = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({r0_rdata[1], r0_rvalid[1], mem_cs[1]} !== 10'h000) begin
            errors++;
            $display("FAIL midreset_clear got d%h rv%b cs%b exp 00 0 0", r0_rdata[1], r0_rvalid[1], mem_cs[1]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({r0_rvalid[1], r0_rdata[1]} !== 9'h000) begin
                errors++;
                $display("FAIL midreset_no_rvalid cycle %0d got rv%b d%h exp 0 00", c, r0_rvalid[1], r0_rdata[1]);
            end
        end
        r0_req[1] = 1'b1; r0_wr[1] = 1'b1; r0_addr[1] = 4'h4; r0_wdata[1] = 8'h44;
        r1_req[1] = 1'b1; r1_wr[1] = 1'b1; r1_addr[1] = 4'h5; r1_wdata[1] = 8'h55;
        tick();
        checks++;
        if ({r0_ack[1], r1_ack[1], mem_addr[1]} !== {1'b1, 1'b0, 4'h4}) begin
            errors++;
            $display("FAIL midreset_r0_first got ack0=%b ack1=%b a%h exp 1 0 4", r0_ack[1], r1_ack[1], mem_addr[1]);
        end
        clear_inputs(1);
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_lat1();
        test_back_to_back();
        test_read_lat3();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port memory (addr_in/data_in/wr_en/op_en/cs/data_out).
- Accepts one held command per requester, issues it as a single-cycle memory access, and returns read data to the winning requester after a fixed memory read latency.
- Sits between the requester agents and the memory DUT; one access is outstanding at a time.

Parameters:
- ADDR_WIDTH, 4, memory address width.
- DATA_WIDTH, 8, memory data width.
- RD_LATENCY, 1, cycles from the memory sampling a read command to data_out being valid. Legal range is 1..4.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rN_req  input  1  (N=0,1) command request; held with its fields stable until rN_ack.
- rN_wr  input  1  1=write, 0=read.
- rN_addr  input  ADDR_WIDTH  command address.
- rN_wdata  input  DATA_WIDTH  write data.
- rN_ack  output  1  one-cycle pulse: command issued to memory.
- rN_rdata  output  DATA_WIDTH  read data; holds the last value returned to this requester.
- rN_rvalid  output  1  one-cycle pulse: rN_rdata is new.
- mem_addr  output  ADDR_WIDTH  to memory addr_in.
- mem_data_in  output  DATA_WIDTH  to memory data_in.
- mem_wr_en  output  1  to memory wr_en.
- mem_op_en  output  1  to memory op_en.
- mem_cs  output  1  to memory cs.
- mem_data_out  input  DATA_WIDTH  from memory data_out.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs 0; state IDLE; latency counter 0.
  - Round-robin pointer set so r0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any rN_req is high, select the winner, latch wr/addr/wdata and the winner id into registers, and go to ISSUE.
  - If neither request is high, stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - On contention, the requester not granted last wins. The pointer updates only on a grant.
- ISSUE (exactly one cycle, cycle T):
  - mem_cs=1, mem_op_en=1, mem_wr_en=latched wr, mem_addr=latched addr.
  - mem_data_in=latched wdata for a write, 0 for a read.
  - Winner's rN_ack=1 in this cycle.
  - Next state: IDLE if write; WAIT if read, with counter loaded to RD_LATENCY.
- Outside ISSUE: mem_cs, mem_op_en and mem_wr_en are 0, and mem_addr/mem_data_in are 0.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reads 1, mem_data_out is sampled into the winner's rN_rdata register and the next state is RESP.
  - WAIT lasts RD_LATENCY cycles (T+1..T+RD_LATENCY).
- RESP (cycle T+RD_LATENCY+1):
  - Winner's rN_rvalid=1 for this one cycle.
  - rN_rdata is stable from this cycle until that requester's next read response.
  - Next state: IDLE.
- Throughput and latency:
  - Write: 2 cycles per access (IDLE, ISSUE).
  - Read: RD_LATENCY+3 cycles per access.
  - Read data is presented RD_LATENCY+1 cycles after the ISSUE cycle.
- Request handshake:
  - The requester drops or changes its request only after ack.
  - The arbiter returns to IDLE no earlier than the cycle after ack, so a held request is never granted twice.
  - A request arriving during ISSUE/WAIT/RESP waits; no requester is starved. Worst-case wait is one access by the other requester.
- Dropping rN_req before ack is illegal; a command already latched completes regardless.
- Requests are ignored while not in IDLE; fields are sampled only in IDLE.
- The non-winning requester's rdata/rvalid are unaffected by the other's access.
- Reset mid-operation:
  - An in-flight read is aborted; no rvalid is produced.
  - rdata registers clear to 0.
  - After release, behaviour is as from power-on.
- Counter width: 3 bits (covers RD_LATENCY up to 4).

Test Plan:
1. Assert reset_n=0 mid-simulation with random inputs -> every output 0 immediately, without waiting for a clock edge; after release with no requests, mem_cs stays 0.
2. r0 write addr=4'h3 wdata=8'hA5 -> one cycle with mem_cs=mem_op_en=mem_wr_en=1, mem_addr=3, mem_data_in=A5, and r0_ack=1 in the same cycle; no rvalid; idle again the next cycle.
3. After test 2, r1 read addr=4'h3, memory model RD_LATENCY=1 -> ISSUE cycle T with mem_wr_en=0 and r1_ack=1; r1_rvalid=1 in T+2 with r1_rdata=A5; r0_rvalid stays 0 and r0_rdata is unchanged.
4. r0 and r1 both requesting writes continuously from reset -> ack order r0,r1,r0,r1; mem_cs pulses every 2nd cycle with alternating addresses.
5. Build with RD_LATENCY=3, r0 read of a preloaded 8'h5C -> r0_rvalid exactly 4 cycles after ISSUE with r0_rdata=5C; an r1 request raised during WAIT is acked only in the ISSUE cycle after RESP.
6. r0 read issued, reset_n pulsed low during WAIT -> no r0_rvalid ever appears; r0_rdata=0; after release, simultaneous requests grant r0 first.
